// File: rtl/rx_backend.sv
// Receive back end: packs each received frame with its error flags and queues it
// in a first-word-fall-through FIFO with a sticky overrun flag.
module rx_backend #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cr_ds_i,
    input  logic [10:0]              frame_i,
    input  logic                     parity_err_i,
    input  logic                     frame_err_i,
    input  logic                     frame_valid_i,
    input  logic                     rx_read_i,
    input  logic                     ovr_clr_i,
    output logic [7:0]               rx_data_o,
    output logic                     rx_pe_o,
    output logic                     rx_fe_o,
    output logic                     rxne_o,
    output logic                     rxfull_o,
    output logic                     ovr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovr;

    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          overrun;
    logic [7:0]    data_in;
    logic [9:0]    entry;
    logic [9:0]    head;
    logic          unused_frame_hi;

    // Frame bits above bit 7 carry stop/parity positions and are not stored.
    assign unused_frame_hi = ^frame_i[10:8];

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = rx_read_i & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push    = frame_valid_i & (~full | pop);
    assign overrun = frame_valid_i & full & ~pop;

    assign data_in = cr_ds_i ? frame_i[7:0] : {1'b0, frame_i[6:0]};
    assign entry   = {frame_err_i, parity_err_i, data_in};

    always_ff @(posedge clk_i) begin
        if (push && rst_i) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // A new overrun wins over a clear in the same cycle.
            if (overrun) begin
                ovr <= 1'b1;
            end else if (ovr_clr_i) begin
                ovr <= 1'b0;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign rx_data_o = empty ? 8'h00 : head[7:0];
    assign rx_pe_o   = ~empty & head[8];
    assign rx_fe_o   = ~empty & head[9];
    assign rxne_o    = ~empty;
    assign rxfull_o  = full;
    assign ovr_o     = ovr;
    assign count_o   = count;

endmodule

// File: tb/tb_rx_backend.sv
// Directed bench for rx_backend (DEPTH = 8): push/pop, 7/8-bit packing, overrun,
// simultaneous push/pop corner cases and asynchronous reset.
module tb_rx_backend;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        cr_ds_i = 1'b1;
    logic [10:0] frame_i = '0;
    logic        parity_err_i = 1'b0;
    logic        frame_err_i = 1'b0;
    logic        frame_valid_i = 1'b0;
    logic        rx_read_i = 1'b0;
    logic        ovr_clr_i = 1'b0;
    logic [7:0]  rx_data_o;
    logic        rx_pe_o;
    logic        rx_fe_o;
    logic        rxne_o;
    logic        rxfull_o;
    logic        ovr_o;
    logic [3:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    rx_backend #(.DEPTH(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cr_ds_i       (cr_ds_i),
        .frame_i       (frame_i),
        .parity_err_i  (parity_err_i),
        .frame_err_i   (frame_err_i),
        .frame_valid_i (frame_valid_i),
        .rx_read_i     (rx_read_i),
        .ovr_clr_i     (ovr_clr_i),
        .rx_data_o     (rx_data_o),
        .rx_pe_o       (rx_pe_o),
        .rx_fe_o       (rx_fe_o),
        .rxne_o        (rxne_o),
        .rxfull_o      (rxfull_o),
        .ovr_o         (ovr_o),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with optional push and/or pop; strobes drop afterwards.
    task automatic cycle(input logic do_push, input logic ds, input logic [10:0] frm,
                         input logic pe, input logic fe, input logic do_pop, input logic clr);
        cr_ds_i       = ds;
        frame_i       = frm;
        parity_err_i  = pe;
        frame_err_i   = fe;
        frame_valid_i = do_push;
        rx_read_i     = do_pop;
        ovr_clr_i     = clr;
        tick();
        frame_valid_i = 1'b0;
        rx_read_i     = 1'b0;
        ovr_clr_i     = 1'b0;
        parity_err_i  = 1'b0;
        frame_err_i   = 1'b0;
    endtask

    task automatic push8(input logic [7:0] b);
        cycle(1'b1, 1'b1, {3'b000, b}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        cycle(1'b0, 1'b1, 11'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_count", count_o, 0);
        check("rst_rxne", rxne_o, 0);
        check("rst_full", rxfull_o, 0);
        check("rst_data", rx_data_o, 0);
        check("rst_ovr", ovr_o, 0);
        tick();
        tick();
        rst_i = 1'b1;

        // Single push, 8-bit
        cycle(1'b1, 1'b1, 11'h5A5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("p1_data", rx_data_o, 8'hA5);
        check("p1_rxne", rxne_o, 1);
        check("p1_count", count_o, 1);
        check("p1_pe", rx_pe_o, 0);
        check("p1_fe", rx_fe_o, 0);
        pop1();
        check("p1_pop_count", count_o, 0);

        // 7-bit mode with parity error
        cycle(1'b1, 1'b0, 11'h0FF, 1'b1, 1'b0, 1'b0, 1'b0);
        check("m7_data", rx_data_o, 8'h7F);
        check("m7_pe", rx_pe_o, 1);
        check("m7_fe", rx_fe_o, 0);
        pop1();
        check("m7_pop_rxne", rxne_o, 0);
        check("m7_pop_data", rx_data_o, 0);
        check("m7_pop_pe", rx_pe_o, 0);

        // Pop on empty is ignored
        pop1();
        check("empty_pop_count", count_o, 0);
        check("empty_pop_ovr", ovr_o, 0);

        // Frame error flag travels with entry; bits 10:8 ignored
        cycle(1'b1, 1'b1, 11'h13C, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 11'h7C3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fe_data", rx_data_o, 8'h3C);
        check("fe_flag", rx_fe_o, 1);
        check("fe_count", count_o, 2);
        pop1();
        check("hi_data", rx_data_o, 8'hC3);
        check("hi_fe", rx_fe_o, 0);
        pop1();

        // Fill and overrun
        for (int i = 0; i < 8; i++) push8(8'(i));
        check("fill_count", count_o, 8);
        check("fill_full", rxfull_o, 1);
        check("fill_ovr", ovr_o, 0);
        push8(8'h08);
        check("ovr_count", count_o, 8);
        check("ovr_full", rxfull_o, 1);
        check("ovr_set", ovr_o, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_%0d", i), rx_data_o, i);
            pop1();
        end
        check("drain_rxne", rxne_o, 0);
        check("drain_ovr_sticky", ovr_o, 1);
        cycle(1'b0, 1'b1, 11'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_ovr", ovr_o, 0);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) push8(8'(8'h10 + i));
        cycle(1'b1, 1'b1, 11'h0AA, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fpp_count", count_o, 8);
        check("fpp_ovr", ovr_o, 0);
        check("fpp_full", rxfull_o, 1);
        check("fpp_head", rx_data_o, 8'h11);
        for (int i = 0; i < 7; i++) pop1();
        check("fpp_last", rx_data_o, 8'hAA);
        pop1();
        check("fpp_empty", count_o, 0);

        // Push and pop together when empty, then at partial fill
        cycle(1'b1, 1'b1, 11'h055, 1'b0, 1'b0, 1'b1, 1'b0);
        check("epp_count", count_o, 1);
        check("epp_data", rx_data_o, 8'h55);
        cycle(1'b1, 1'b1, 11'h066, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ppp1_count", count_o, 1);
        check("ppp1_data", rx_data_o, 8'h66);
        push8(8'h77);
        cycle(1'b1, 1'b1, 11'h088, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ppp2_count", count_o, 2);
        check("ppp2_data", rx_data_o, 8'h77);

        // Overrun with simultaneous clear keeps flag set
        for (int i = 0; i < 6; i++) push8(8'(8'h90 + i));
        check("ovc_full", rxfull_o, 1);
        cycle(1'b1, 1'b1, 11'h0EE, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovc_ovr", ovr_o, 1);
        check("ovc_head", rx_data_o, 8'h77);
        check("ovc_count", count_o, 8);
        cycle(1'b0, 1'b1, 11'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovc_clr", ovr_o, 0);

        // Asynchronous reset mid-operation
        push8(8'hEF);
        check("ar_ovr_pre", ovr_o, 1);
        for (int i = 0; i < 5; i++) pop1();
        check("ar_count_pre", count_o, 3);
        #2;
        rst_i = 1'b0;
        #1;
        check("ar_count", count_o, 0);
        check("ar_rxne", rxne_o, 0);
        check("ar_ovr", ovr_o, 0);
        check("ar_data", rx_data_o, 0);
        check("ar_full", rxfull_o, 0);
        frame_valid_i = 1'b1;
        frame_i = 11'h033;
        tick();
        frame_valid_i = 1'b0;
        check("ar_ignore_push", count_o, 0);
        #2;
        rst_i = 1'b1;
        rx_read_i = 1'b1;
        tick();
        rx_read_i = 1'b0;
        check("ar_pop_count", count_o, 0);
        check("ar_pop_rxne", rxne_o, 0);
        push8(8'h3D);
        check("ar_resume_count", count_o, 1);
        check("ar_resume_data", rx_data_o, 8'h3D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
